uart_rx_fifo: RTL and testbench

//  Receive buffer directly downstream of the UART receiver (as_rx). Captures each byte

---
 rtl/uart_pack.sv | 6 +
 rtl/uart_fifo_mem.sv | 25 ++
 rtl/uart_rx_fifo.sv | 92 +++++++++
 tb/tb_uart_rx_fifo.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pack.sv
// Shared UART constants: data width and default receive-FIFO geometry.
package uart_pack;
  localparam int uart_width       = 8;
  localparam int UART_FIFO_DEPTH  = 16;
  localparam int UART_FIFO_THRESH = 8;
endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH storage with synchronous write and asynchronous read,
// shaped to map onto distributed RAM.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // No reset on the array so it stays a plain RAM primitive.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: FWFT read port, level/status flags,
// sticky overrun and an interrupt request for the CPU register block.
module uart_rx_fifo
  import uart_pack::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int THRESH = UART_FIFO_THRESH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    rx_rdy_i,
  input  logic [uart_width-1:0]   rx_data_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic                    clr_ovr_i,
  input  logic [1:0]              irq_en_i,
  output logic [uart_width-1:0]   rd_data_o,
  output logic                    rd_valid_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    full_o,
  output logic                    thresh_o,
  output logic                    overrun_o,
  output logic                    irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] THRESH_L = PW'(THRESH);
  localparam logic [PW-1:0] ONE_L    = PW'(1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overrun_q, overrun_d;
  logic          empty, full;
  logic          pop_ok, push_ok, ovr_set, mem_we;

  // The extra MSB on each pointer separates the full and empty cases.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // A pop in the same cycle makes room, so a push into a full FIFO is not an overrun.
  always_comb begin
    pop_ok    = pop_i & ~empty;
    push_ok   = rx_rdy_i & (~full | pop_ok);
    ovr_set   = rx_rdy_i & full & ~pop_ok & ~flush_i;
    mem_we    = push_ok & ~flush_i;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q;
    if (flush_i) begin
      wr_ptr_d = rd_ptr_q;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + ONE_L;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE_L;
    end
    if (ovr_set)        overrun_d = 1'b1;
    else if (clr_ovr_i) overrun_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (uart_width),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (rx_data_i),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_data_o)
  );

  assign level_o    = wr_ptr_q - rd_ptr_q;
  assign rd_valid_o = ~empty;
  assign full_o     = full;
  assign thresh_o   = (level_o >= THRESH_L);
  assign overrun_o  = overrun_q;
  assign irq_o      = (thresh_o & irq_en_i[0]) | (overrun_o & irq_en_i[1]);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_uart_rx_fifo;
  import uart_pack::*;

  localparam int DEPTH  = UART_FIFO_DEPTH;
  localparam int THRESH = UART_FIFO_THRESH;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  rx_rdy_i;
  logic [uart_width-1:0] rx_data_i;
  logic                  pop_i;
  logic                  flush_i;
  logic                  clr_ovr_i;
  logic [1:0]            irq_en_i;
  logic [uart_width-1:0] rd_data_o;
  logic                  rd_valid_o;
  logic [LW-1:0]         level_o;
  logic                  full_o;
  logic                  thresh_o;
  logic                  overrun_o;
  logic                  irq_o;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] modelQ [$];
  bit         modelOvr;

  uart_rx_fifo dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_rdy_i   (rx_rdy_i),
    .rx_data_i  (rx_data_i),
    .pop_i      (pop_i),
    .flush_i    (flush_i),
    .clr_ovr_i  (clr_ovr_i),
    .irq_en_i   (irq_en_i),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o),
    .level_o    (level_o),
    .full_o     (full_o),
    .thresh_o   (thresh_o),
    .overrun_o  (overrun_o),
    .irq_o      (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Compare every output against the reference model.
  task automatic checkModel(input string tag);
    int lvl;
    bit th;
    lvl = modelQ.size();
    th  = (lvl >= THRESH);
    checkOutput({tag, " level"},    32'(level_o),    32'(lvl));
    checkOutput({tag, " valid"},    32'(rd_valid_o), 32'(lvl != 0));
    checkOutput({tag, " full"},     32'(full_o),     32'(lvl == DEPTH));
    checkOutput({tag, " thresh"},   32'(thresh_o),   32'(th));
    checkOutput({tag, " overrun"},  32'(overrun_o),  32'(modelOvr));
    checkOutput({tag, " irq"},      32'(irq_o),      32'((th & irq_en_i[0]) | (modelOvr & irq_en_i[1])));
    if (lvl != 0) checkOutput({tag, " rd_data"}, 32'(rd_data_o), 32'(modelQ[0]));
  endtask

  // One clock of stimulus; the model advances from its pre-edge state.
  task automatic applyStimulus(input logic rdy, input logic [7:0] data, input logic pop,
                               input logic flush, input logic clr);
    bit wasFull, popped;
    rx_rdy_i  = rdy;
    rx_data_i = data;
    pop_i     = pop;
    flush_i   = flush;
    clr_ovr_i = clr;
    @(posedge clk_i);
    wasFull = (modelQ.size() == DEPTH);
    if (flush) begin
      modelQ.delete();
      if (clr) modelOvr = 0;
    end else begin
      popped = pop && (modelQ.size() != 0);
      if (popped) void'(modelQ.pop_front());
      if (rdy && (!wasFull || popped)) modelQ.push_back(data);
      if (rdy && wasFull && !popped) modelOvr = 1;
      else if (clr) modelOvr = 0;
    end
    #1;
    rx_rdy_i  = 1'b0;
    pop_i     = 1'b0;
    flush_i   = 1'b0;
    clr_ovr_i = 1'b0;
  endtask

  initial begin
    rst_i     = 1'b1;
    rx_rdy_i  = 1'b0;
    rx_data_i = '0;
    pop_i     = 1'b0;
    flush_i   = 1'b0;
    clr_ovr_i = 1'b0;
    irq_en_i  = 2'b11;
    modelOvr  = 0;
    repeat (2) @(posedge clk_i);
    #1;
    checkModel("reset");
    rst_i = 1'b0;

    // Scenario 1: three bytes in, three out in order.
    applyStimulus(1, 8'h41, 0, 0, 0);
    applyStimulus(1, 8'h42, 0, 0, 0);
    applyStimulus(1, 8'h43, 0, 0, 0);
    checkOutput("t1 level", 32'(level_o), 32'd3);
    checkModel("t1");
    checkOutput("t1 pop0", 32'(rd_data_o), 32'h41);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t1 pop1", 32'(rd_data_o), 32'h42);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t1 pop2", 32'(rd_data_o), 32'h43);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t1 empty", 32'(rd_valid_o), 32'd0);

    // Scenario 2: fill, overflow once, drain, clear overrun.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'(i), 0, 0, 0);
    applyStimulus(1, 8'hAA, 0, 0, 0);
    checkOutput("t2 full", 32'(full_o), 32'd1);
    checkOutput("t2 overrun", 32'(overrun_o), 32'd1);
    checkOutput("t2 level", 32'(level_o), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("t2 drain", 32'(rd_data_o), 32'(i));
      applyStimulus(0, 0, 1, 0, 0);
    end
    checkOutput("t2 drained", 32'(rd_valid_o), 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t2 clr", 32'(overrun_o), 32'd0);

    // Scenario 3: push with pop while full.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'(8'h60 + i), 0, 0, 0);
    applyStimulus(1, 8'h55, 1, 0, 0);
    checkOutput("t3 overrun", 32'(overrun_o), 32'd0);
    checkOutput("t3 level", 32'(level_o), 32'd16);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t3 last", 32'(rd_data_o), 32'h55);
    applyStimulus(0, 0, 1, 0, 0);
    checkModel("t3");

    // Scenario 4: threshold interrupt.
    irq_en_i = 2'b01;
    for (int i = 0; i < THRESH - 1; i++) applyStimulus(1, 8'(i), 0, 0, 0);
    checkOutput("t4 thresh lo", 32'(thresh_o), 32'd0);
    checkOutput("t4 irq lo", 32'(irq_o), 32'd0);
    applyStimulus(1, 8'h07, 0, 0, 0);
    checkOutput("t4 thresh hi", 32'(thresh_o), 32'd1);
    checkOutput("t4 irq hi", 32'(irq_o), 32'd1);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t4 thresh drop", 32'(thresh_o), 32'd0);
    checkOutput("t4 irq drop", 32'(irq_o), 32'd0);
    applyStimulus(0, 0, 0, 1, 0);
    checkModel("t4 flush");

    // Scenario 5: pop on empty with push, then flush beats push.
    applyStimulus(1, 8'h99, 1, 0, 0);
    checkOutput("t5 level", 32'(level_o), 32'd1);
    checkOutput("t5 data", 32'(rd_data_o), 32'h99);
    applyStimulus(1, 8'h77, 0, 1, 0);
    checkOutput("t5 flush level", 32'(level_o), 32'd0);
    checkOutput("t5 flush ovr", 32'(overrun_o), 32'd0);

    // Scenario 6: asynchronous reset with level 5 and overrun set.
    irq_en_i = 2'b11;
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1, 8'(i), 0, 0, 0);
    for (int i = 0; i < DEPTH - 5; i++) applyStimulus(0, 0, 1, 0, 0);
    checkModel("t6 pre");
    #2;
    rst_i = 1'b1;
    #1;
    modelQ.delete();
    modelOvr = 0;
    checkModel("t6 async");
    #3;
    rst_i = 1'b0;
    applyStimulus(1, 8'h12, 0, 0, 0);
    checkOutput("t6 readback", 32'(rd_data_o), 32'h12);
    checkModel("t6 post");

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      irq_en_i = 2'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 99) < 55), 8'($urandom),
                    ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 3),
                    ($urandom_range(0, 99) < 5));
      checkModel("rand");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
